iter_shift_mult: RTL and testbench
==================================

# iter_shift_mult

Multi-cycle arithmetic unit for the single-cycle CPU's extended instructions: signed/unsigned 8-bit multiply (low byte), logical/arithmetic shifts and rotate-right, one bit per clock. It sits directly downstream of `reg_file`. It consumes the two register read ports (OUT1 → DATA1, OUT2 → DATA2). It returns its result to the `reg_file` write port (RESULT → IN, DONE → WRITE). While BUSY is high it holds the PC stalled.

## Interface
- DATA_WIDTH, 8, operand/result width; the counter is sized to hold DATA_WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled on a CLK rising edge while the unit is IDLE or DONE.
- SELECT  in  3  operation: 000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR; 101–111 are illegal.
- DATA1  in  DATA_WIDTH  multiplicand / value to shift (from reg_file OUT1).
- DATA2  in  DATA_WIDTH  multiplier / unsigned shift amount (from reg_file OUT2).
- RESULT  out  DATA_WIDTH  result; held stable from DONE until the next accepted START.
- BUSY  out  1  high while iterating; drives the PC stall.
- DONE  out  1  one-cycle pulse, result valid; drives reg_file WRITE.

## Operation
- States are IDLE, RUN and DONE.
- On an accepted START:
  - latch DATA1, DATA2 and SELECT;
  - load the iteration count N;
  - next state is RUN, or DONE directly if N = 0.
- Iteration count N:
  - MUL: N = 8.
  - SLL, SRL, SRA: N = min(DATA2, 8), with DATA2 treated as unsigned.
  - ROR: N = DATA2 mod 8.
  - Illegal SELECT: N = 0 and RESULT = 0.
- MUL, per step:
  - if the multiplier LSB is 1, add the multiplicand to the accumulator;
  - shift the multiplicand left 1 and the multiplier right 1.
  - RESULT is the low 8 bits of the product, so signed and unsigned results are identical and overflow is discarded.
- Shifts, per step:
  - SLL shifts left and fills 0.
  - SRL shifts right and fills 0.
  - SRA shifts right and fills with bit 7.
  - ROR moves bit 0 into bit 7.
- Out-of-range shift amounts: a SLL/SRL amount of 8 or more yields 0; a SRA amount of 8 or more yields 0x00 or 0xFF according to the sign.
- N = 0 with a legal SELECT (shift amount 0, or ROR by a multiple of 8): RESULT = DATA1.
- In RUN, the unit decrements the count each edge. The edge that performs the last step moves the state to DONE.
- DONE lasts exactly one cycle, then the state returns to IDLE unless START is high on that edge.
- START is ignored while in RUN. There is no queueing.

## Timing
- Reset values: state IDLE, RESULT 0x00, BUSY 0, DONE 0, all internal registers 0.
- Accept edge k → steps execute on edges k+1 … k+N → DONE is high in the cycle after edge k+N.
  - MUL: DONE 8 cycles after the accept edge.
  - N = 0: DONE in the cycle immediately after edge k.
- BUSY is high exactly while the state is RUN. It is low in IDLE and in DONE.
- START sampled high during DONE starts a new operation; DONE still deasserts after its single cycle.
- RESET asserted mid-RUN aborts the operation immediately (asynchronously), with no DONE pulse.
- Operand inputs may change freely after the accept edge, because all operands are latched.

## Structure
- The shared package `cpu_defs` holds:
  - SELECT encodings (OP_MUL, OP_SLL, OP_SRL, OP_SRA, OP_ROR);
  - state encodings (ST_IDLE, ST_RUN, ST_DONE);
  - the DATA_WIDTH default.
- The sub-module `shift_step` is a combinational single-bit step (op, value, fill) → next value. It is shared by all shift ops and by the MUL multiplicand/multiplier shifts.
- The control FSM, counter and MUL accumulator live in the top module.

## Test plan
- MUL 5×3: START with SELECT=000, DATA1=0x05, DATA2=0x03 → BUSY high for 8 cycles, then DONE pulse with RESULT=0x0F.
- MUL −3×7: DATA1=0xFD, DATA2=0x07 → RESULT=0xEB after 8 cycles; a following reg_file write stores 0xEB.
- Shifts:
  - SRA 0x90 by 3 → RESULT=0xF2, DONE 3 cycles after accept;
  - ROR 0x81 by 1 → 0xC0;
  - SRL 0x80 by 200 → 0x00 after 8 cycles.
- Zero and illegal:
  - SLL 0x5A by 0 → DONE in the cycle after accept, BUSY never high, RESULT=0x5A;
  - SELECT=110 → DONE next cycle with RESULT=0x00.
- Handshake:
  - START pulsed mid-RUN → ignored, and the original result is unchanged;
  - START held high through DONE → a back-to-back second operation is accepted.
- RESET asserted at step 4 of a MUL → outputs go to 0 immediately with no DONE; a new START afterwards completes normally.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the CPU extended-instruction units: SELECT codes,
// iterative-unit state codes, step direction and the default datapath width.
package cpu_defs;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROR = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    STEP_LEFT  = 1'b0,
    STEP_RIGHT = 1'b1
  } step_dir_t;

  // SELECT codes above OP_ROR are reserved.
  function automatic logic op_legal(input logic [2:0] sel);
    return sel <= OP_ROR;
  endfunction

endpackage

// File: rtl/iter_shift_mult_shift_step.sv
// Single-bit shift step: moves the value one place left or right and
// inserts the supplied fill bit at the vacated end.
module shift_step
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = cpu_defs::DATA_WIDTH
) (
  input  step_dir_t             op,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] result
);

  // One-place shift with caller-chosen fill.
  always_comb begin
    result = value;
    case (op)
      STEP_LEFT:  result = {value[DATA_WIDTH-2:0], fill};
      STEP_RIGHT: result = {fill, value[DATA_WIDTH-1:1]};
      default:    result = value;
    endcase
  end

endmodule

// File: rtl/iter_shift_mult.sv
// Iterative multiply / shift / rotate unit, one bit per clock.
// Control FSM, step counter and the multiply accumulator live here;
// the per-bit moves are done by two shift_step instances.
module iter_shift_mult #(
  parameter int DATA_WIDTH = cpu_defs::DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [2:0]            SELECT,
  input  logic [DATA_WIDTH-1:0] DATA1,
  input  logic [DATA_WIDTH-1:0] DATA2,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  BUSY,
  output logic                  DONE
);
  import cpu_defs::*;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] W_LIM    = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DATA_WIDTH);

  state_t                state, next_state;
  logic [2:0]            sel_q;
  logic [DATA_WIDTH-1:0] val_q, mplr_q, acc_q, result_q;
  logic [CW-1:0]         cnt_q, n_load;
  logic                  accept, last_step, start_legal;
  step_dir_t             val_dir;
  logic                  val_fill;
  logic [DATA_WIDTH-1:0] val_step, mplr_step, acc_next;

  assign accept      = START && (state != ST_RUN);
  assign last_step   = (cnt_q == CW'(1));
  assign start_legal = op_legal(SELECT);
  assign RESULT      = result_q;

  // Iteration count for the operation being requested on START.
  always_comb begin
    n_load = '0;
    case (SELECT)
      OP_MUL:                 n_load = CNT_FULL;
      OP_SLL, OP_SRL, OP_SRA: n_load = (DATA2 >= W_LIM) ? CNT_FULL : CW'(DATA2);
      OP_ROR:                 n_load = CW'(DATA2 & (W_LIM - 1'b1));
      default:                n_load = '0;
    endcase
  end

  // Direction and fill for the value register: MUL multiplicand and SLL go
  // left; SRA replicates the sign, ROR recirculates bit 0.
  always_comb begin
    val_dir  = STEP_RIGHT;
    val_fill = 1'b0;
    case (sel_q)
      OP_MUL, OP_SLL: val_dir = STEP_LEFT;
      OP_SRA:         val_fill = val_q[DATA_WIDTH-1];
      OP_ROR:         val_fill = val_q[0];
      default:        val_dir = STEP_RIGHT;
    endcase
  end

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_val_step (
    .op     (val_dir),
    .value  (val_q),
    .fill   (val_fill),
    .result (val_step)
  );

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_mplr_step (
    .op     (STEP_RIGHT),
    .value  (mplr_q),
    .fill   (1'b0),
    .result (mplr_step)
  );

  assign acc_next = mplr_q[0] ? (acc_q + val_q) : acc_q;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) next_state = (n_load == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (last_step) next_state = ST_DONE;
      end
      ST_DONE: begin
        DONE = 1'b1;
        if (START) next_state = (n_load == '0) ? ST_DONE : ST_RUN;
        else       next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand latch, per-step datapath update and result capture.
  // Zero-step requests write RESULT at the accept edge, so DONE in the next
  // cycle already sees the final value just like the iterated cases.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_q    <= '0;
      val_q    <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      sel_q  <= SELECT;
      val_q  <= start_legal ? DATA1 : '0;
      mplr_q <= DATA2;
      acc_q  <= '0;
      cnt_q  <= n_load;
      if (n_load == '0) result_q <= start_legal ? DATA1 : '0;
    end else if (state == ST_RUN) begin
      cnt_q  <= cnt_q - 1'b1;
      val_q  <= val_step;
      mplr_q <= mplr_step;
      acc_q  <= acc_next;
      if (last_step) result_q <= (sel_q == OP_MUL) ? acc_next : val_step;
    end
  end

endmodule

// File: tb/tb_iter_shift_mult.sv
// Directed-vector bench for iter_shift_mult.
module tb_iter_shift_mult;
  import cpu_defs::*;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [2:0] SELECT;
  logic [7:0] DATA1, DATA2, RESULT;
  logic       BUSY, DONE;
  logic [7:0] rf_word;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
  } vec_t;

  always #5 CLK = ~CLK;

  // Stand-in for the reg_file write port.
  always @(posedge CLK) if (DONE) rf_word <= RESULT;

  iter_shift_mult #(.DATA_WIDTH(8)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  // Present a request for one edge, then scramble operands.
  task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    START  = 1'b1;
    SELECT = s;
    DATA1  = a;
    DATA2  = b;
    @(posedge CLK); #1;
    START  = 1'b0;
    SELECT = 3'($urandom);
    DATA1  = 8'($urandom);
    DATA2  = 8'($urandom);
  endtask

  // Count edges and BUSY cycles until DONE, bounded.
  task automatic wait_done(output int lat, output int busy, output bit ok);
    lat  = 0;
    busy = 0;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      if (BUSY) busy++;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    #2;
    n_cmp++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", RESULT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", DONE); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
      n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL idle_flags: got %b want 00", {BUSY, DONE}); end
    end
  endtask

  task automatic test_mul;
    vec_t v [4];
    int lat, busy;
    bit ok;
    v = '{'{OP_MUL, 8'h05, 8'h03, 8'h0F, 8},
          '{OP_MUL, 8'hFD, 8'h07, 8'hEB, 8},
          '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8},
          '{OP_MUL, 8'h80, 8'h02, 8'h00, 8}};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].sel, v[i].a, v[i].b);
      wait_done(lat, busy, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mul[%0d] timeout: no DONE within 20 cycles", i); end
      n_cmp++; if (lat != v[i].lat) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (busy != v[i].lat) begin n_fail++; $display("FAIL mul[%0d] busy_cycles: got %0d want %0d", i, busy, v[i].lat); end
      n_cmp++; if (RESULT !== v[i].res) begin n_fail++; $display("FAIL mul[%0d] result: got %h want %h", i, RESULT, v[i].res); end
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL mul[%0d] done_pulse: got %b want 0", i, DONE); end
      n_cmp++; if (RESULT !== v[i].res) begin n_fail++; $display("FAIL mul[%0d] result_hold: got %h want %h", i, RESULT, v[i].res); end
      n_cmp++; if (rf_word !== v[i].res) begin n_fail++; $display("FAIL mul[%0d] rf_write: got %h want %h", i, rf_word, v[i].res); end
    end
  endtask

  task automatic test_shifts;
    vec_t v [7];
    int lat, busy;
    bit ok;
    v = '{'{OP_SRA, 8'h90, 8'h03, 8'hF2, 3},
          '{OP_ROR, 8'h81, 8'h01, 8'hC0, 1},
          '{OP_SRL, 8'h80, 8'hC8, 8'h00, 8},
          '{OP_SRA, 8'h80, 8'h09, 8'hFF, 8},
          '{OP_SLL, 8'h01, 8'h07, 8'h80, 7},
          '{OP_ROR, 8'hB4, 8'h0B, 8'h96, 3},
          '{OP_SRA, 8'h70, 8'h02, 8'h1C, 2}};
    for (int i = 0; i < 7; i++) begin
      issue(v[i].sel, v[i].a, v[i].b);
      wait_done(lat, busy, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL shift[%0d] timeout: no DONE within 20 cycles", i); end
      n_cmp++; if (lat != v[i].lat) begin n_fail++; $display("FAIL shift[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (busy != v[i].lat) begin n_fail++; $display("FAIL shift[%0d] busy_cycles: got %0d want %0d", i, busy, v[i].lat); end
      n_cmp++; if (RESULT !== v[i].res) begin n_fail++; $display("FAIL shift[%0d] result: got %h want %h", i, RESULT, v[i].res); end
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL shift[%0d] done_pulse: got %b want 0", i, DONE); end
    end
  endtask

  task automatic test_zero_illegal;
    vec_t v [5];
    int lat, busy;
    bit ok;
    v = '{'{OP_SLL, 8'h5A, 8'h00, 8'h5A, 0},
          '{3'b110, 8'h3C, 8'h02, 8'h00, 0},
          '{OP_ROR, 8'hA5, 8'h08, 8'hA5, 0},
          '{3'b111, 8'hFF, 8'hFF, 8'h00, 0},
          '{OP_SRA, 8'hC3, 8'h00, 8'hC3, 0}};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].sel, v[i].a, v[i].b);
      wait_done(lat, busy, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero[%0d] timeout: no DONE within 20 cycles", i); end
      n_cmp++; if (lat != 0) begin n_fail++; $display("FAIL zero[%0d] latency: got %0d want 0", i, lat); end
      n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL zero[%0d] busy: got %b want 0", i, BUSY); end
      n_cmp++; if (RESULT !== v[i].res) begin n_fail++; $display("FAIL zero[%0d] result: got %h want %h", i, RESULT, v[i].res); end
      @(posedge CLK); #1;
      n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL zero[%0d] after: got %b want 00", i, {BUSY, DONE}); end
    end
  endtask

  task automatic test_start_mid_run;
    int lat, busy;
    bit ok;
    issue(OP_MUL, 8'h05, 8'h03);
    repeat (3) begin @(posedge CLK); #1; end
    START = 1'b1; SELECT = OP_SLL; DATA1 = 8'hFF; DATA2 = 8'h01;
    @(posedge CLK); #1;
    START = 1'b0;
    n_cmp++; if ({BUSY, DONE} !== 2'b10) begin n_fail++; $display("FAIL midrun_flags: got %b want 10", {BUSY, DONE}); end
    wait_done(lat, busy, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrun timeout: no DONE within 20 cycles"); end
    n_cmp++; if (lat + 4 != 8) begin n_fail++; $display("FAIL midrun_latency: got %0d want 8", lat + 4); end
    n_cmp++; if (RESULT !== 8'h0F) begin n_fail++; $display("FAIL midrun_result: got %h want 0f", RESULT); end
    @(posedge CLK); #1;
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL midrun_after: got %b want 00", {BUSY, DONE}); end
  endtask

  task automatic test_back_to_back;
    int lat, busy;
    bit ok;
    issue(OP_SRL, 8'hF0, 8'h02);
    wait_done(lat, busy, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first timeout: no DONE within 20 cycles"); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 2", lat); end
    n_cmp++; if (RESULT !== 8'h3C) begin n_fail++; $display("FAIL b2b_first_result: got %h want 3c", RESULT); end
    issue(OP_MUL, 8'h06, 8'h07);
    n_cmp++; if ({BUSY, DONE} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept_flags: got %b want 10", {BUSY, DONE}); end
    n_cmp++; if (RESULT !== 8'h3C) begin n_fail++; $display("FAIL b2b_result_hold: got %h want 3c", RESULT); end
    wait_done(lat, busy, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_second timeout: no DONE within 20 cycles"); end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
    n_cmp++; if (RESULT !== 8'h2A) begin n_fail++; $display("FAIL b2b_second_result: got %h want 2a", RESULT); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat, busy;
    bit ok;
    issue(OP_MUL, 8'h0B, 8'h0D);
    repeat (3) begin @(posedge CLK); #1; end
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++; if (RESULT !== 8'h00) begin n_fail++; $display("FAIL rst_mid_result: got %h want 00", RESULT); end
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 00", {BUSY, DONE}); end
    repeat (2) begin
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL rst_hold_done: got %b want 0", DONE); end
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL rst_release_flags: got %b want 00", {BUSY, DONE}); end
    issue(OP_MUL, 8'h0B, 8'h0D);
    wait_done(lat, busy, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_rerun timeout: no DONE within 20 cycles"); end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL rst_rerun_latency: got %0d want 8", lat); end
    n_cmp++; if (RESULT !== 8'h8F) begin n_fail++; $display("FAIL rst_rerun_result: got %h want 8f", RESULT); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_shifts();
    test_zero_illegal();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
